grid_readout: RTL and testbench



---
 rtl/grid_readout.sv | 155 +++++++++++++++
 tb/tb_grid_readout.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_readout.sv
// ---------------------------------------------------------------------------
// grid_readout
//
// Purpose:
//   Read-only companion to the system memory. On START (in IDLE) the full
//   grid vector MEM_IN is captured into a snapshot register. The snapshot is
//   then streamed out least-significant word first as word_size-bit words
//   over a valid/ready handshake. The block never writes the memory.
//
// Parameters:
//   data_size  width of the grid vector (must be a multiple of word_size)
//   word_size  width of each streamed word
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   MEM_IN       grid contents from the memory output
//   START        readout request, sampled only in IDLE
//   ABORT        synchronous cancel of a readout in progress
//   WORD_OUT     current output word (0 when not sending)
//   WORD_VALID   WORD_OUT holds a valid word
//   WORD_READY   downstream accepts the word on this edge
//   WORD_LAST    marks the final word of the readout
//   BUSY         readout in progress
//   DONE         one-cycle pulse after the final word is accepted
//   WORD_PARITY  (only with READOUT_PARITY_EN defined) XOR reduction of
//                WORD_OUT
//
// Build option:
//   READOUT_PARITY_EN  adds the WORD_PARITY output.
// ---------------------------------------------------------------------------
module grid_readout #(
    parameter int data_size = 64,
    parameter int word_size = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [data_size-1:0] MEM_IN,
    input  logic                 START,
    input  logic                 ABORT,
    output logic [word_size-1:0] WORD_OUT,
    output logic                 WORD_VALID,
    input  logic                 WORD_READY,
    output logic                 WORD_LAST,
    output logic                 BUSY,
    output logic                 DONE
`ifdef READOUT_PARITY_EN
    ,
    output logic                 WORD_PARITY
`endif
);

    localparam int NUM_WORDS = data_size / word_size;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    // Reject a grid that does not split into whole words at elaboration.
    if ((data_size % word_size) != 0) begin : g_size_check
        $error("grid_readout: data_size must be a multiple of word_size");
    end

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [data_size-1:0]   r_snapshot;
    logic [IDX_W-1:0]       r_index;
    logic                   r_done;

    logic                   w_sending;
    logic                   w_is_last;
    logic                   w_transfer;
    logic                   w_last_xfer;
    logic [word_size-1:0]   w_words [NUM_WORDS];

    // Split the snapshot into word slices; word 0 is the LSB slice.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign w_words[gi] = r_snapshot[gi*word_size +: word_size];
        end
    endgenerate

    assign w_sending  = (r_state == S_SEND);
    assign w_is_last  = (r_index == LAST_IDX);
    // ABORT outranks a handshake on the same edge, so it cancels the transfer.
    assign w_transfer  = w_sending && WORD_READY && !ABORT;
    assign w_last_xfer = w_transfer && w_is_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (ABORT || w_last_xfer) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_snapshot <= '0;
            r_index    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_xfer;
            if (!w_sending) begin
                // START is only honoured here, so a request during SEND
                // (including the last-word edge) is simply dropped.
                if (START) begin
                    r_snapshot <= MEM_IN;
                    r_index    <= '0;
                end
            end else if (ABORT) begin
                r_index <= '0;
            end else if (w_transfer) begin
                r_index <= w_is_last ? '0 : (r_index + ONE_IDX);
            end
        end
    end

    // Outputs are decoded purely from registers; WORD_READY never reaches them.
    assign WORD_VALID = w_sending;
    assign BUSY       = w_sending;
    assign WORD_LAST  = w_sending && w_is_last;
    assign WORD_OUT   = w_sending ? w_words[r_index] : '0;
    assign DONE       = r_done;

`ifdef READOUT_PARITY_EN
    assign WORD_PARITY = ^WORD_OUT;
`endif

endmodule

// File: tb/tb_grid_readout.sv
// ---------------------------------------------------------------------------
// tb_grid_readout
//
// Directed stimulus for grid_readout (64-bit grid, 8-bit words). The
// stimulus process pushes the expected word stream into a queue when it
// issues START; an independent monitor pops and compares on every accepted
// word, tracks the DONE pulse and checks that stalled words hold still.
// ---------------------------------------------------------------------------
module tb_grid_readout;

    localparam int DS = 64;
    localparam int WS = 8;
    localparam int NW = DS / WS;

    logic          CLK;
    logic          RESET;
    logic [DS-1:0] MEM_IN;
    logic          START;
    logic          ABORT;
    logic [WS-1:0] WORD_OUT;
    logic          WORD_VALID;
    logic          WORD_READY;
    logic          WORD_LAST;
    logic          BUSY;
    logic          DONE;
`ifdef READOUT_PARITY_EN
    logic          WORD_PARITY;
`endif

    grid_readout #(.data_size(DS), .word_size(WS)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_IN     (MEM_IN),
        .START      (START),
        .ABORT      (ABORT),
        .WORD_OUT   (WORD_OUT),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .WORD_LAST  (WORD_LAST),
        .BUSY       (BUSY),
        .DONE       (DONE)
`ifdef READOUT_PARITY_EN
        ,
        .WORD_PARITY(WORD_PARITY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Expected entry: {last, word}
    logic [WS:0] exp_q [$];

    int done_count = 0;
    int xfer_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- Monitor / scoreboard ----------------
    logic          done_pend = 1'b0;
    logic          stall     = 1'b0;
    logic [WS-1:0] held_word = '0;
    logic          held_last = 1'b0;

    always @(negedge CLK) begin
        logic [WS:0] e;
        if (!RESET) begin
            done_pend = 1'b0;
            stall     = 1'b0;
        end else begin
            check("done_pulse", 64'(DONE), 64'(done_pend));
            if (DONE) done_count++;
            if (stall) begin
                check("stall_valid", 64'(WORD_VALID), 64'd1);
                check("stall_word", 64'(WORD_OUT), 64'(held_word));
                check("stall_last", 64'(WORD_LAST), 64'(held_last));
            end
            if (WORD_VALID && WORD_READY && !ABORT) begin
                xfer_count++;
                $display("xfer word=%02h last=%0b", WORD_OUT, WORD_LAST);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(WORD_OUT), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(WORD_OUT), 64'(e[WS-1:0]));
                    check("last", 64'(WORD_LAST), 64'(e[WS]));
`ifdef READOUT_PARITY_EN
                    check("parity", 64'(WORD_PARITY), 64'(^e[WS-1:0]));
`endif
                end
            end
            done_pend = WORD_VALID && WORD_READY && WORD_LAST && !ABORT;
            stall     = WORD_VALID && !WORD_READY && !ABORT;
            held_word = WORD_OUT;
            held_last = WORD_LAST;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_expect(input logic [DS-1:0] data);
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back({(i == NW - 1) ? 1'b1 : 1'b0, data[i*WS +: WS]});
        end
    endtask

    // Issue START with MEM_IN=capture, then check first-word latency.
    task automatic start_readout(input logic [DS-1:0] capture, input logic [WS-1:0] first);
        check("idle_valid", 64'(WORD_VALID), 64'd0);
        MEM_IN = capture;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        check("first_valid", 64'(WORD_VALID), 64'd1);
        check("first_busy", 64'(BUSY), 64'd1);
        check("first_word", 64'(WORD_OUT), 64'(first));
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_after(input string tag);
        // Called in the cycle right after the last transfer (DONE cycle).
        check({tag, "_done_valid"}, 64'(WORD_VALID), 64'd0);
        check({tag, "_done_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_done"}, 64'(DONE), 64'd1);
        tick();
        check({tag, "_post_done"}, 64'(DONE), 64'd0);
        check({tag, "_post_busy"}, 64'(BUSY), 64'd0);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int d0, x0, n;
        RESET      = 1'b0;
        MEM_IN     = '0;
        START      = 1'b0;
        ABORT      = 1'b0;
        WORD_READY = 1'b0;
        #3;
        check("rst_word", 64'(WORD_OUT), 64'd0);
        check("rst_valid", 64'(WORD_VALID), 64'd0);
        check("rst_last", 64'(WORD_LAST), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        tick();
        RESET = 1'b1;
        tick();

        // 1. Basic readout
        WORD_READY = 1'b1;
        d0 = done_count; x0 = xfer_count;
        push_expect(64'h0123456789ABCDEF);
        start_readout(64'h0123456789ABCDEF, 8'hEF);
        for (int i = 0; i < NW - 1; i++) tick();
        check("basic_last_word", 64'(WORD_OUT), 64'h01);
        check("basic_last_flag", 64'(WORD_LAST), 64'd1);
        tick();
        check_idle_after("basic");
        check("basic_xfers", 64'(xfer_count - x0), 64'(NW));
        check("basic_dones", 64'(done_count - d0), 64'd1);

        // 2. Backpressure on word AB
        x0 = xfer_count;
        push_expect(64'h0123456789ABCDEF);
        start_readout(64'h0123456789ABCDEF, 8'hEF);
        tick();
        tick();
        check("bp_present", 64'(WORD_OUT), 64'hAB);
        WORD_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", 64'(WORD_OUT), 64'hAB);
            check("bp_hold_valid", 64'(WORD_VALID), 64'd1);
        end
        WORD_READY = 1'b1;
        wait_drain();
        tick();
        check("bp_xfers", 64'(xfer_count - x0), 64'(NW));

        // 3. Snapshot isolation
        push_expect(64'hFFFF_0000_FFFF_0000);
        start_readout(64'hFFFF_0000_FFFF_0000, 8'h00);
        MEM_IN = '0;
        wait_drain();
        tick();

        // 4a. START while busy and START on the last-transfer edge
        d0 = done_count;
        push_expect(64'h1122334455667788);
        start_readout(64'h1122334455667788, 8'h88);
        MEM_IN = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!WORD_LAST && n < 20) begin
            tick();
            n++;
        end
        check("edge_found_last", 64'(WORD_LAST), 64'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        check_idle_after("edge");
        tick();
        check("edge_no_restart", 64'(WORD_VALID), 64'd0);
        check("edge_one_done", 64'(done_count - d0), 64'd1);

        // 4b. ABORT after third transfer, then restart from word 0
        d0 = done_count;
        push_expect(64'h0123456789ABCDEF);
        start_readout(64'h0123456789ABCDEF, 8'hEF);
        tick(); tick(); tick();
        check("abort_at_word", 64'(WORD_OUT), 64'h89);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        exp_q.delete();
        check("abort_valid", 64'(WORD_VALID), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        tick();
        check("abort_no_done", 64'(done_count - d0), 64'd0);
        push_expect(64'h0123456789ABCDEF);
        start_readout(64'h0123456789ABCDEF, 8'hEF);
        wait_drain();
        tick();

        // 5. Asynchronous reset mid-transfer
        push_expect(64'hCAFEBABE_DEADBEEF);
        start_readout(64'hCAFEBABE_DEADBEEF, 8'hEF);
        tick();
        #2;
        RESET = 1'b0;
        #1;
        check("arst_word", 64'(WORD_OUT), 64'd0);
        check("arst_valid", 64'(WORD_VALID), 64'd0);
        check("arst_last", 64'(WORD_LAST), 64'd0);
        check("arst_busy", 64'(BUSY), 64'd0);
        check("arst_done", 64'(DONE), 64'd0);
        exp_q.delete();
        tick();
        RESET = 1'b1;
        tick();
        x0 = xfer_count;
        push_expect(64'h0123456789ABCDEF);
        start_readout(64'h0123456789ABCDEF, 8'hEF);
        wait_drain();
        tick();
        check("arst_full_xfers", 64'(xfer_count - x0), 64'(NW));

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
